// File: rtl/branch_resolve.sv
// Registered branch resolution stage: compares the resolved outcome with the prediction,
// emits redirect/predictor-update pulses and buffers completion packets for the CDB.
module branch_resolve #(
  parameter int unsigned TAG_BITS     = 6,
  parameter int unsigned ROB_IDX_BITS = 5,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic                    in_take,
  input  logic [31:0]             in_target,
  input  logic                    in_pred_take,
  input  logic [31:0]             in_pred_target,
  input  logic                    in_is_jump,
  input  logic [TAG_BITS-1:0]     in_dest_tag,
  input  logic [ROB_IDX_BITS-1:0] in_rob_idx,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [TAG_BITS-1:0]     cdb_tag,
  output logic [31:0]             cdb_value,
  output logic [ROB_IDX_BITS-1:0] cdb_rob_idx,
  output logic                    cdb_mispredict,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic [ROB_IDX_BITS-1:0] redirect_rob_idx,
  output logic                    bp_upd_valid,
  output logic [31:0]             bp_upd_pc,
  output logic                    bp_upd_take,
  output logic [31:0]             bp_upd_target,
  input  logic                    flush
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  typedef enum logic {
    ST_IDLE,
    ST_RECOVER
  } state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]     tag;
    logic [31:0]             value;
    logic [ROB_IDX_BITS-1:0] rob_idx;
    logic                    mispredict;
  } pkt_t;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  pkt_t                mem_q [FIFO_DEPTH];

  logic                    redirect_valid_q;
  logic [31:0]             redirect_pc_q;
  logic [ROB_IDX_BITS-1:0] redirect_rob_idx_q;
  logic                    bp_upd_valid_q;
  logic [31:0]             bp_upd_pc_q;
  logic                    bp_upd_take_q;
  logic [31:0]             bp_upd_target_q;

  logic acc;
  logic pop;
  logic mispredict;
  pkt_t new_pkt;
  pkt_t head_pkt;

  // in_ready deliberately ignores cdb_ready: a full buffer blocks even in its pop cycle
  assign in_ready   = !reset && (state_q == ST_IDLE) &&
                      (count_q < CNT_BITS'(FIFO_DEPTH)) && !flush;
  assign acc        = in_valid && in_ready;
  assign cdb_valid  = (count_q != '0);
  assign pop        = cdb_valid && cdb_ready;
  assign mispredict = (in_take != in_pred_take) ||
                      (in_take && (in_target != in_pred_target));

  always_comb begin
    new_pkt.tag        = in_is_jump ? in_dest_tag : '0;
    new_pkt.value      = in_is_jump ? (in_pc + 32'h4) : '0;
    new_pkt.rob_idx    = in_rob_idx;
    new_pkt.mispredict = mispredict;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (acc) tail_d = tail_q + PTR_BITS'(1);
      if (pop) head_d = head_q + PTR_BITS'(1);
      case ({acc, pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
      if ((state_q == ST_IDLE) && acc && mispredict) state_d = ST_RECOVER;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      count_q            <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      redirect_rob_idx_q <= '0;
      bp_upd_valid_q     <= 1'b0;
      bp_upd_pc_q        <= '0;
      bp_upd_take_q      <= 1'b0;
      bp_upd_target_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      // acc is already low during flush, so both pulses are suppressed then
      redirect_valid_q <= acc && mispredict;
      bp_upd_valid_q   <= acc;
      if (acc) begin
        mem_q[tail_q]   <= new_pkt;
        bp_upd_pc_q     <= in_pc;
        bp_upd_take_q   <= in_take;
        bp_upd_target_q <= in_target;
        if (mispredict) begin
          redirect_pc_q      <= in_target;
          redirect_rob_idx_q <= in_rob_idx;
        end
      end
    end
  end

  assign head_pkt         = mem_q[head_q];
  assign cdb_tag          = head_pkt.tag;
  assign cdb_value        = head_pkt.value;
  assign cdb_rob_idx      = head_pkt.rob_idx;
  assign cdb_mispredict   = head_pkt.mispredict;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign redirect_rob_idx = redirect_rob_idx_q;
  assign bp_upd_valid     = bp_upd_valid_q;
  assign bp_upd_pc        = bp_upd_pc_q;
  assign bp_upd_take      = bp_upd_take_q;
  assign bp_upd_target    = bp_upd_target_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed expectations checked with immediate assertions.
module tb_branch_resolve;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_take;
  logic [31:0] in_target;
  logic        in_pred_take;
  logic [31:0] in_pred_target;
  logic        in_is_jump;
  logic [5:0]  in_dest_tag;
  logic [4:0]  in_rob_idx;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [4:0]  cdb_rob_idx;
  logic        cdb_mispredict;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  redirect_rob_idx;
  logic        bp_upd_valid;
  logic [31:0] bp_upd_pc;
  logic        bp_upd_take;
  logic [31:0] bp_upd_target;
  logic        flush;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_resolve #(.TAG_BITS(6), .ROB_IDX_BITS(5), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_take(in_take),
    .in_target(in_target), .in_pred_take(in_pred_take), .in_pred_target(in_pred_target),
    .in_is_jump(in_is_jump), .in_dest_tag(in_dest_tag), .in_rob_idx(in_rob_idx),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_rob_idx(cdb_rob_idx), .cdb_mispredict(cdb_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_rob_idx(redirect_rob_idx),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_take(bp_upd_take),
    .bp_upd_target(bp_upd_target), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1ns later
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic take, input logic [31:0] tgt,
                       input logic ptake, input logic [31:0] ptgt, input logic jump,
                       input logic [5:0] tag, input logic [4:0] rob);
    in_valid = 1'b1; in_pc = pc; in_take = take; in_target = tgt;
    in_pred_take = ptake; in_pred_target = ptgt; in_is_jump = jump;
    in_dest_tag = tag; in_rob_idx = rob;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_take = 1'b0; in_target = '0;
    in_pred_take = 1'b0; in_pred_target = '0; in_is_jump = 1'b0; in_dest_tag = '0;
    in_rob_idx = '0; cdb_ready = 1'b1; flush = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_bp_valid", 32'(bp_upd_valid), 32'd0);
    chk("rst_cdb_value", cdb_value, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b0; #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Correct prediction, non-jump: tag forced to 0, value 0
    cdb_ready = 1'b0;
    drive(32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 6'd5, 5'd3);
    step(); in_valid = 1'b0;
    chk("ok_bp_valid", 32'(bp_upd_valid), 32'd1);
    chk("ok_bp_pc", bp_upd_pc, 32'h100);
    chk("ok_bp_target", bp_upd_target, 32'h140);
    chk("ok_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("ok_cdb_valid", 32'(cdb_valid), 32'd1);
    chk("ok_cdb_mispredict", 32'(cdb_mispredict), 32'd0);
    chk("ok_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("ok_cdb_value", cdb_value, 32'd0);
    step();
    chk("ok_bp_pulse_end", 32'(bp_upd_valid), 32'd0);
    chk("ok_hold_valid", 32'(cdb_valid), 32'd1);
    chk("ok_hold_rob", 32'(cdb_rob_idx), 32'd3);
    cdb_ready = 1'b1;
    step();
    chk("ok_popped", 32'(cdb_valid), 32'd0);

    // Direction mispredict then flush
    drive(32'h200, 1'b0, 32'h204, 1'b1, 32'h999, 1'b0, 6'd0, 5'd9);
    step(); in_valid = 1'b0;
    chk("dm_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("dm_redirect_pc", redirect_pc, 32'h204);
    chk("dm_redirect_rob", 32'(redirect_rob_idx), 32'd9);
    chk("dm_in_ready", 32'(in_ready), 32'd0);
    chk("dm_cdb_mispredict", 32'(cdb_mispredict), 32'd1);
    step();
    chk("dm_redirect_pulse_end", 32'(redirect_valid), 32'd0);
    chk("dm_recover_ready", 32'(in_ready), 32'd0);
    chk("dm_drained", 32'(cdb_valid), 32'd0);
    flush = 1'b1;
    step(); flush = 1'b0; #1;
    chk("dm_flush_ready", 32'(in_ready), 32'd1);
    chk("dm_flush_cdb", 32'(cdb_valid), 32'd0);

    // JALR at top of address space: link wraps to 0
    drive(32'hFFFF_FFFC, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 6'd7, 5'd4);
    step(); in_valid = 1'b0;
    chk("jalr_value", cdb_value, 32'h0);
    chk("jalr_tag", 32'(cdb_tag), 32'd7);
    chk("jalr_redirect", 32'(redirect_valid), 32'd0);
    chk("jalr_bp_valid", 32'(bp_upd_valid), 32'd1);
    step();
    chk("jalr_popped", 32'(cdb_valid), 32'd0);

    // Backpressure: two accepted, third blocked
    cdb_ready = 1'b0;
    drive(32'h400, 1'b0, 32'h404, 1'b0, 32'h0, 1'b1, 6'd1, 5'd1);
    step();
    drive(32'h500, 1'b0, 32'h504, 1'b0, 32'h0, 1'b1, 6'd2, 5'd2);
    #1;
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    step();
    drive(32'h600, 1'b0, 32'h604, 1'b0, 32'h0, 1'b1, 6'd3, 5'd3);
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    step(); in_valid = 1'b0;
    chk("bp_head_value", cdb_value, 32'h404);
    chk("bp_head_rob", 32'(cdb_rob_idx), 32'd1);
    cdb_ready = 1'b1; #1;
    chk("bp_full_pop_ready", 32'(in_ready), 32'd0);
    step();
    chk("bp_second_value", cdb_value, 32'h504);
    chk("bp_second_tag", 32'(cdb_tag), 32'd2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_third_dropped", 32'(cdb_valid), 32'd0);

    // Simultaneous push and pop
    drive(32'h1000, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b1, 6'd10, 5'd10);
    step();
    drive(32'h2000, 1'b0, 32'h2004, 1'b0, 32'h0, 1'b1, 6'd11, 5'd11);
    step(); in_valid = 1'b0;
    chk("pp_head_value", cdb_value, 32'h2004);
    chk("pp_head_valid", 32'(cdb_valid), 32'd1);
    step();
    chk("pp_empty", 32'(cdb_valid), 32'd0);

    // Target-only mispredict
    drive(32'h2F0, 1'b1, 32'h300, 1'b1, 32'h310, 1'b0, 6'd0, 5'd6);
    step(); in_valid = 1'b0;
    chk("tm_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("tm_redirect_pc", redirect_pc, 32'h300);
    chk("tm_cdb_mispredict", 32'(cdb_mispredict), 32'd1);
    flush = 1'b1;
    step(); flush = 1'b0; #1;
    chk("tm_flush_ready", 32'(in_ready), 32'd1);

    // Flush together with in_valid: input dropped
    cdb_ready = 1'b0;
    drive(32'h3000, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b1, 6'd9, 5'd8);
    flush = 1'b1; #1;
    chk("fv_ready_low", 32'(in_ready), 32'd0);
    step(); in_valid = 1'b0; flush = 1'b0;
    chk("fv_cdb_empty", 32'(cdb_valid), 32'd0);
    chk("fv_bp_valid", 32'(bp_upd_valid), 32'd0);
    chk("fv_redirect_valid", 32'(redirect_valid), 32'd0);

    // Reset with two buffered packets and a pending redirect
    drive(32'h700, 1'b0, 32'h704, 1'b0, 32'h0, 1'b1, 6'd4, 5'd4);
    step();
    drive(32'h800, 1'b1, 32'h900, 1'b1, 32'h880, 1'b0, 6'd0, 5'd5);
    step(); in_valid = 1'b0;
    chk("rs_pre_redirect", 32'(redirect_valid), 32'd1);
    chk("rs_pre_cdb", 32'(cdb_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("rs_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rs_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rs_bp_valid", 32'(bp_upd_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; cdb_ready = 1'b1; #1;
    chk("rs_ready_after", 32'(in_ready), 32'd1);
    step();
    chk("rs_still_empty", 32'(cdb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered resolution stage directly downstream of the combinational branch unit. Accepts a resolved outcome (taken flag and target), compares it with the front-end prediction, and produces three things: a one-cycle redirect on mispredict, a one-cycle predictor-training update, and a buffered completion packet (link value plus mispredict status) for the CDB/ROB. After a mispredict it holds off new branches until the ROB-driven flush arrives.

## Interface
Parameters:
- TAG_BITS, default 6: physical destination tag width.
- ROB_IDX_BITS, default 5: ROB index width.
- FIFO_DEPTH, default 2: completion buffer entries; power of two, ≥2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  resolved branch present.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  32  PC of the branch.
- in_take  in  1  resolved direction (always 1 for JAL/JALR).
- in_target  in  32  resolved next PC (PC+4 when not taken).
- in_pred_take  in  1  predicted direction.
- in_pred_target  in  32  predicted target.
- in_is_jump  in  1  JAL/JALR: writes link register.
- in_dest_tag  in  TAG_BITS  destination tag; 0 = no write.
- in_rob_idx  in  ROB_IDX_BITS  ROB entry of the branch.
- cdb_valid  out  1  completion packet at FIFO head.
- cdb_ready  in  1  CDB grant; pops head when cdb_valid is high.
- cdb_tag  out  TAG_BITS  head destination tag.
- cdb_value  out  32  head link value.
- cdb_rob_idx  out  ROB_IDX_BITS  head ROB index.
- cdb_mispredict  out  1  head was mispredicted.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  correct next PC.
- redirect_rob_idx  out  ROB_IDX_BITS  ROB index of the mispredicted branch.
- bp_upd_valid  out  1  one-cycle predictor update pulse.
- bp_upd_pc  out  32  branch PC.
- bp_upd_take  out  1  resolved direction.
- bp_upd_target  out  32  resolved target.
- flush  in  1  ROB recovery flush; clears the stage.

## Operation
- Accept: acc = in_valid & in_ready. Inputs are ignored when acc is low.
- in_ready = (state==IDLE) & (count < FIFO_DEPTH) & !flush. It has no combinational dependence on cdb_ready, so a full FIFO blocks input even in the cycle it pops.
- mispredict = (in_take != in_pred_take) | (in_take & (in_target != in_pred_target)).
- Link value = in_pc + 32'h4, truncated mod 2^32, so 0xFFFFFFFC gives 0. For !in_is_jump, cdb_value = 0 and cdb_tag is forced to 0.
- On acc, push {tag, value, rob_idx, mispredict} into the FIFO. The FIFO is a circular buffer with head/tail pointers and a count; pointers wrap at FIFO_DEPTH.
- On acc, register bp_upd_* from the inputs. bp_upd_valid pulses on every accepted branch, including jumps.
- On acc & mispredict, register redirect_pc = in_target and redirect_rob_idx = in_rob_idx, pulse redirect_valid, and set state to RECOVER.
- State machine:
  - IDLE → RECOVER on acc & mispredict.
  - RECOVER → IDLE on flush.
  - In RECOVER, in_ready = 0. The FIFO keeps draining so the mispredicted branch can complete.
- flush (either state): next cycle count = 0, pointers = 0, state = IDLE, and redirect/bp pulses are suppressed. flush takes priority over a simultaneous acc; the input is dropped and in_ready is 0 in that cycle anyway. A simultaneous pop is discarded.
- Simultaneous push and pop with count < FIFO_DEPTH: count is unchanged and both pointers advance.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after. cdb_valid=0, redirect_valid=0, bp_upd_valid=0. All data outputs = 0. state=IDLE, count=0, pointers=0.
- Input accepted in cycle N:
  - redirect_* and bp_upd_* are valid in N+1 for exactly one cycle.
  - The packet is visible on cdb_* in N+1 if the FIFO was empty.
- Throughput is one branch per cycle while the FIFO is not full and state is IDLE.
- Mispredict accepted in N: in_ready = 0 from N+1 until the cycle after flush.
- cdb_* outputs hold steady while cdb_valid=1 and cdb_ready=0.
- Reset mid-operation discards all buffered packets and any pending pulse.

## Test plan
- Correct prediction: pc=0x100, take=1, target=0x140, pred=1/0x140, is_jump=0 → N+1: bp_upd_valid=1, redirect_valid=0, cdb_valid=1, cdb_mispredict=0, cdb_tag=0.
- Direction mispredict: pc=0x200, take=0, target=0x204, pred_take=1 → N+1: redirect_valid=1, redirect_pc=0x204, in_ready=0 until flush; flush → in_ready=1 next cycle, cdb_valid=0.
- JALR link and wrap: pc=0xFFFFFFFC, is_jump=1, tag=7, take=1, target=0x80, pred=1/0x80 → cdb_value=0x0, cdb_tag=7, no redirect.
- Backpressure: cdb_ready=0 and 3 back-to-back valid inputs → 2 accepted, in_ready=0 on the third; cdb_ready=1 → packets pop in order, one per cycle, and in_ready returns.
- Target-only mispredict and priority: take=1, pred_take=1, target 0x300 vs predicted 0x310 → redirect_pc=0x300. Separately, flush together with in_valid → input dropped, FIFO empty next cycle.
- Reset mid-stream: assert reset with 2 buffered packets and a pending redirect → next cycle all valids are 0 and count=0.
